obstacle_board: RTL
===================

# obstacle_board

Downstream stage of the new-row generator. Holds the falling-obstacle playfield as a `board_height` × `board_width` shift register. It loads each freshly generated top row and shifts the board down one row per update. It checks the bottom row against the player column, raises `game_Over` on collision, and counts rows the player has dodged. `game_Over` feeds back to the row generator and the display logic; the flattened board drives the LED-matrix renderer.

## Interface
- `board_width`, 9: columns per row; must match the row generator.
- `board_height`, 8: rows on the board. Row 0 is the top; row `board_height-1` is the bottom (player row).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low (`reset` = 0 clears all state immediately, independent of `clk`).
- `row_data`  in  `board_width`  new top row from the row generator; valid the cycle after `update_obstacle`.
- `update_obstacle`  in  1  board-advance tick (same signal the row generator uses); level-sampled each cycle.
- `player_pos`  in  `$clog2(board_width)`  player column index in the bottom row, bit 0 = column 0.
- `start`  in  1  restart request; honoured only in OVER.
- `board`  out  `board_height*board_width`  playfield; row r = `board[r*board_width +: board_width]`.
- `game_Over`  out  1  1 while in OVER.
- `score`  out  10  number of non-empty rows shifted off the bottom without collision; saturates at 1023.

## Operation
- **States.** PLAY and OVER. `game_Over` = (state == OVER), registered.
- **Reset values.** State PLAY, `board` = 0, `score` = 0, `game_Over` = 0, `shift_pending` = 0.
- **shift_pending.** Internal 1-bit register. In PLAY it loads `update_obstacle` every edge; in OVER it is forced to 0.
- **Shift.** Occurs at an edge where state is PLAY, `shift_pending` = 1 and there is no collision.
  - `board` row 0 ← `row_data`.
  - Row k ← row k-1 for k = 1..`board_height-1`.
  - The old bottom row is discarded.
- **Score.** On a shift, if the discarded bottom row ≠ 0, `score` increments by 1, saturating at 1023.
- **Collision.** Evaluated combinationally every cycle from the registered bottom row: collision = bottom row bit[`player_pos`].
  - A `player_pos` ≥ `board_width` is treated as `board_width-1`.
- **PLAY → OVER.** Taken at any edge where collision = 1.
  - Collision has priority over a pending shift: at that edge the board does not shift, `score` does not change, and `shift_pending` clears.
  - A collision can come from an obstacle arriving or from the player moving into an occupied column.
- **OVER.** `board` and `score` are frozen; `update_obstacle` and `row_data` are ignored.
- **OVER → PLAY.** Taken on an edge with `start` = 1. At that edge `board` ← 0 and `score` ← 0.
- **start in PLAY.** Ignored.
- **Reset mid-operation.** Asserting `reset` at any point, including mid-shift or in OVER, returns everything to the reset values immediately.

## Timing
- Row load latency: `update_obstacle` high at edge t → row generator updates `row_data` at t → `board` row 0 = that `row_data` after edge t+1.
- A row loaded at edge t+1 reaches the bottom row after `board_height-1` further shifts. It is scored when it is shifted out, on the `board_height`-th shift after loading.
- Collision → `game_Over` = 1 after the next rising edge, i.e. one-cycle latency from the bottom-row/`player_pos` condition.
- `start` at edge t in OVER → `game_Over` = 0 and `board` = 0 after edge t.
  - `update_obstacle` sampled at that same edge t is discarded: `shift_pending` is 0 there.
- Back-to-back `update_obstacle` (high every cycle) → one shift per cycle, each loading the previous cycle's `row_data`.
- `update_obstacle` held high across the PLAY→OVER edge → no shift occurs in OVER.

## Test plan
- **Reset.** Run shifts until the board is non-zero and `score` = 3, then pull `reset` low between clock edges → `board` = 0, `score` = 0, `game_Over` = 0 with no clock edge.
- **Load latency.** `player_pos` = 8, `row_data` = 9'h005, one-cycle `update_obstacle` pulse at edge t → row 0 = 9'h005 after t+1 (still 0 after t); all other rows 0.
- **Dodge.** `player_pos` = 4, single row 9'h005 followed by empty rows, `board_height` = 8 pulses → row at bottom after 8th shift, no `game_Over`; 9th pulse → `score` = 1, `game_Over` = 0.
- **Arrival collision.** `player_pos` = 0, row 9'h001 pushed down. The edge that places it in the bottom row leaves `game_Over` = 0; the next edge sets `game_Over` = 1. A shift pending at that edge is suppressed: board unchanged, `score` = 0.
- **Move-in collision.** Bottom row = 9'h010, `player_pos` 3 → 4 with no `update_obstacle` → `game_Over` = 1 after the next edge.
- **OVER / restart.** In OVER, toggle `update_obstacle` and `row_data` for 10 cycles → `board` and `score` unchanged. Pulse `start` → `board` = 0, `score` = 0, `game_Over` = 0 after that edge. The next `update_obstacle` pulse loads row 0 one cycle later, as in the load-latency case.

Source files
------------

// File: rtl/obstacle_board.sv
// Falling-obstacle playfield: shifts generated rows down the board, detects
// player collisions on the bottom row and counts dodged rows.
module obstacle_board #(
  parameter int board_width  = 9,
  parameter int board_height = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [board_width-1:0]              row_data,
  input  logic                                update_obstacle,
  input  logic [$clog2(board_width)-1:0]      player_pos,
  input  logic                                start,
  output logic [board_height*board_width-1:0] board,
  output logic                                game_Over,
  output logic [9:0]                          score
);

  localparam int pos_w      = $clog2(board_width);
  localparam int board_bits = board_height * board_width;

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [board_bits-1:0]    board_r;
  logic [board_bits-1:0]    board_next_s;
  logic [9:0]               score_r;
  logic [9:0]               score_next_s;
  logic                     shift_pending_r;
  logic                     shift_pending_next_s;
  logic                     game_over_r;
  logic [board_width-1:0]   bottom_s;
  logic [pos_w-1:0]         pos_clamped_s;
  logic                     collision_s;

  // Collision check on the registered bottom row; out-of-range columns clamp to the last one
  always_comb begin
    bottom_s = board_r[board_bits-1 -: board_width];
    if (int'(player_pos) >= board_width) begin
      pos_clamped_s = pos_w'(board_width - 1);
    end else begin
      pos_clamped_s = player_pos;
    end
    collision_s = bottom_s[pos_clamped_s];
  end

  // Next-state logic: collision wins over a pending shift, restart clears the board
  always_comb begin
    state_next_s         = state_r;
    board_next_s         = board_r;
    score_next_s         = score_r;
    shift_pending_next_s = 1'b0;
    case (state_r)
      PLAY: begin
        if (collision_s) begin
          state_next_s         = OVER;
          shift_pending_next_s = 1'b0;
        end else begin
          shift_pending_next_s = update_obstacle;
          if (shift_pending_r) begin
            board_next_s = {board_r[board_bits-board_width-1:0], row_data};
            if ((bottom_s != {board_width{1'b0}}) && (score_r != 10'd1023)) begin
              score_next_s = score_r + 10'd1;
            end else begin
              score_next_s = score_r;
            end
          end else begin
            board_next_s = board_r;
          end
        end
      end
      OVER: begin
        if (start) begin
          state_next_s = PLAY;
          board_next_s = {board_bits{1'b0}};
          score_next_s = 10'd0;
        end else begin
          state_next_s = OVER;
        end
      end
      default: begin
        state_next_s = PLAY;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= PLAY;
      board_r         <= {board_bits{1'b0}};
      score_r         <= 10'd0;
      shift_pending_r <= 1'b0;
      game_over_r     <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      board_r         <= board_next_s;
      score_r         <= score_next_s;
      shift_pending_r <= shift_pending_next_s;
      game_over_r     <= (state_next_s == OVER);
    end
  end

  assign board     = board_r;
  assign score     = score_r;
  assign game_Over = game_over_r;

endmodule
